// File: rtl/clk_meter_pkg.sv
// Shared defaults and FSM encoding for the clock frequency meter family.
package clk_meter_pkg;

  localparam int GATE_CYCLES_DEF = 500_000;
  localparam int CNT_W_DEF       = 16;
  localparam int LOST_CYCLES_DEF = 25_000;

  localparam logic ST_SETTLE = 1'b0;
  localparam logic ST_RUN    = 1'b1;

endpackage

// File: rtl/sync_edge_det.sv
// Three-flop synchronizer for an asynchronous input plus a one-cycle rising-edge pulse.
module sync_edge_det (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // r_s1 may go metastable; the edge is taken only from the settled stages.
  assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/clk_freq_meter.sv
// Counts rising edges of an asynchronous input over a fixed gate window and publishes the count.
// SETTLE: first window counts but does not publish | RUN: publish at every window end.
module clk_freq_meter
  import clk_meter_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int LOST_CYCLES = LOST_CYCLES_DEF
) (
  input  logic             i_clk_50MHz,
  input  logic             i_rst,
  input  logic             i_sig_in,
  output logic [CNT_W-1:0] o_freq_count,
  output logic             o_count_valid,
  output logic             o_overflow,
  output logic             o_sig_lost
);

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int LW = (LOST_CYCLES > 1) ? $clog2(LOST_CYCLES) : 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [LW-1:0] LOST_LAST = LW'(LOST_CYCLES - 1);

  logic             w_edge;
  logic             w_at_max;
  logic             w_win_end;
  logic [CNT_W-1:0] w_final;

  logic             r_state;
  logic [GW-1:0]    r_gate_ctr;
  logic [CNT_W-1:0] r_edge_ctr;
  logic             r_ovf_acc;
  logic [LW-1:0]    r_idle_ctr;

  sync_edge_det u_sync (
    .i_clk   (i_clk_50MHz),
    .i_rst   (i_rst),
    .i_async (i_sig_in),
    .o_rise  (w_edge)
  );

  assign w_at_max  = &r_edge_ctr;
  assign w_win_end = (r_gate_ctr == GATE_LAST);
  // An edge in the window's last cycle still belongs to that window.
  assign w_final   = (w_edge && !w_at_max) ? r_edge_ctr + CNT_W'(1) : r_edge_ctr;

  always_ff @(posedge i_clk_50MHz or posedge i_rst) begin
    if (i_rst) begin
      r_gate_ctr <= '0;
    end else if (w_win_end) begin
      r_gate_ctr <= '0;
    end else begin
      r_gate_ctr <= r_gate_ctr + GW'(1);
    end
  end

  always_ff @(posedge i_clk_50MHz or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_SETTLE;
      r_edge_ctr    <= '0;
      r_ovf_acc     <= 1'b0;
      o_freq_count  <= '0;
      o_overflow    <= 1'b0;
      o_count_valid <= 1'b0;
    end else begin
      o_count_valid <= 1'b0;
      if (w_win_end) begin
        r_edge_ctr <= '0;
        r_ovf_acc  <= 1'b0;
        if (r_state == ST_RUN) begin
          o_freq_count  <= w_final;
          o_overflow    <= r_ovf_acc | (w_edge & w_at_max);
          o_count_valid <= 1'b1;
        end else begin
          r_state <= ST_RUN;
        end
      end else if (w_edge) begin
        if (w_at_max) begin
          r_ovf_acc <= 1'b1;
        end else begin
          r_edge_ctr <= r_edge_ctr + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk_50MHz or posedge i_rst) begin
    if (i_rst) begin
      r_idle_ctr <= '0;
      o_sig_lost <= 1'b0;
    end else if (w_edge) begin
      r_idle_ctr <= '0;
      o_sig_lost <= 1'b0;
    end else if (r_idle_ctr == LOST_LAST) begin
      o_sig_lost <= 1'b1;
    end else begin
      r_idle_ctr <= r_idle_ctr + LW'(1);
    end
  end

endmodule

// File: tb/tb_clk_freq_meter.sv
// Scoreboard bench for clk_freq_meter: stimulus pushes expected publishes, a monitor pops on count_valid.
module tb_clk_freq_meter;

  localparam int GATE = 1000;
  localparam int CW   = 8;
  localparam int LOST = 300;

  typedef struct {
    int lo;
    int hi;
    bit ovf;
    int pub;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sig_man = 1'b0;
  logic sig_per = 1'b0;
  logic sig_async = 1'b0;
  logic w_sig;

  int mode = 0;  // 0 manual level, 1 periodic (clock-aligned), 2 free-running async
  int per_period = 100;
  int per_base = 0;
  int per_hi = 50;
  int last_k = 0;
  bit nxt;
  bit async_en = 1'b0;
  int async_off = 1;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t sbq[$];

  logic [CW-1:0] freq;
  logic          valid;
  logic          ovf;
  logic          lost;

  assign w_sig = (mode == 2) ? sig_async : (mode == 1) ? sig_per : sig_man;

  clk_freq_meter #(
    .GATE_CYCLES (GATE),
    .CNT_W       (CW),
    .LOST_CYCLES (LOST)
  ) dut (
    .i_clk_50MHz   (clk),
    .i_rst         (rst),
    .i_sig_in      (w_sig),
    .o_freq_count  (freq),
    .o_count_valid (valid),
    .o_overflow    (ovf),
    .o_sig_lost    (lost)
  );

  initial forever #10 clk = ~clk;

  // cyc = number of rising clock edges since reset release
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Periodic source: goes high on the negedge where (cyc-base) % period == 0;
  // last_k is the posedge at which s1 first captures that rise.
  always @(negedge clk) begin
    nxt = (mode == 1) && (cyc >= per_base) && (((cyc - per_base) % per_period) < per_hi);
    if (nxt && !sig_per) last_k = cyc + 1;
    sig_per = nxt;
  end

  initial begin
    wait (async_en);
    #(async_off);
    forever begin
      sig_async = 1'b1;
      #370;
      sig_async = 1'b0;
      #370;
    end
  end

  task automatic chk(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0d, want %0d..%0d", nm, cyc, act, lo, hi);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && valid !== 1'b0) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid at cyc %0d: got valid=%b freq=%0d, want no publish", cyc, valid, freq);
      end else begin
        e = sbq.pop_front();
        chk("publish_cycle", cyc, e.pub, e.pub);
        chk("freq_count", $isunknown(freq) ? -1 : int'(freq), e.lo, e.hi);
        chk("overflow", $isunknown(ovf) ? -1 : int'(ovf), int'(e.ovf), int'(e.ovf));
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic win_end(input int n, input bit push, input int lo, input int hi, input bit ov);
    wait_cyc(GATE * n - 1);
    if (push) sbq.push_back('{lo, hi, ov, GATE * n});
    @(posedge clk);
  endtask

  task automatic set_per(input int p, input int base);
    per_period = p;
    per_hi = p / 2;
    per_base = base;
    mode = 1;
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_freq"}, int'(freq), 0, 0);
    chk({tag, "_valid"}, int'(valid), 0, 0);
    chk({tag, "_ovf"}, int'(ovf), 0, 0);
    chk({tag, "_lost"}, int'(lost), 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    set_per(100, 0);
    repeat (3) @(negedge clk);
    chk_outs_zero("reset");
    rst = 1'b0;

    // 100-cycle period: 10 edges per 1000-cycle window, first publish at cycle 2000
    win_end(1, 1'b0, 0, 0, 1'b0);
    win_end(2, 1'b1, 10, 10, 1'b0);
    win_end(3, 1'b1, 10, 10, 1'b0);
    // 3-cycle period: ~333 edges saturate the 8-bit counter
    set_per(3, 3000);
    win_end(4, 1'b1, 255, 255, 1'b1);
    set_per(3, 4000);
    win_end(5, 1'b1, 255, 255, 1'b1);
    set_per(100, 5000);
    win_end(6, 1'b1, 9, 11, 1'b0);
    win_end(7, 1'b1, 10, 10, 1'b0);

    // hold low: edge counted at last_k+2, sig_lost visible after posedge last_k+302
    mode = 0;
    sig_man = 1'b0;
    wait_cyc(last_k + 301);
    chk("sig_lost_before", int'(lost), 0, 0);
    wait_cyc(last_k + 302);
    chk("sig_lost_rise", int'(lost), 1, 1);
    win_end(8, 1'b1, 0, 0, 1'b0);

    wait_cyc(8500);
    sig_man = 1'b1;
    wait_cyc(8502);
    chk("sig_lost_hold", int'(lost), 1, 1);
    wait_cyc(8504);
    chk("sig_lost_clear", int'(lost), 0, 0);
    win_end(9, 1'b1, 1, 1, 1'b0);

    // edge counted at posedge 10000 (gate_ctr 999) belongs to window 10
    sig_man = 1'b0;
    wait_cyc(9997);
    sig_man = 1'b1;
    wait_cyc(9998);
    sig_man = 1'b0;
    win_end(10, 1'b1, 1, 1, 1'b0);
    // edge counted at posedge 11001 (gate_ctr 0) belongs to window 12
    wait_cyc(10998);
    sig_man = 1'b1;
    wait_cyc(10999);
    sig_man = 1'b0;
    win_end(11, 1'b1, 0, 0, 1'b0);
    win_end(12, 1'b1, 1, 1, 1'b0);

    set_per(3, 12000);
    win_end(13, 1'b1, 255, 255, 1'b1);
    set_per(3, 13000);
    wait_cyc(13500);
    rst = 1'b1;
    #1;
    chk_outs_zero("midrst");

    repeat (3) @(negedge clk);
    set_per(100, 0);
    @(negedge clk);
    rst = 1'b0;
    win_end(1, 1'b0, 0, 0, 1'b0);
    win_end(2, 1'b1, 10, 10, 1'b0);
    mode = 0;
    sig_man = 1'b0;
    win_end(3, 1'b1, 0, 0, 1'b0);

    // asynchronous 37-cycle period, random phase: 27 or 28 edges per window
    async_off = int'($urandom_range(1, 739));
    mode = 2;
    async_en = 1'b1;
    win_end(4, 1'b1, 20, 28, 1'b0);
    for (int n = 5; n <= 24; n++) win_end(n, 1'b1, 27, 28, 1'b0);

    for (int i = 0; i < 3000 && sbq.size() > 0; i++) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
